// File: rtl/cmul_sched.sv
`default_nettype none
// ============================================================================
// Module   : cmul_sched
// Purpose  : Round-robin scheduler sharing one two-phase complex multiplier
//            between NREQ requesters, with a credit-protected result FIFO.
// Revision : 1.0
// ============================================================================
module cmul_sched #(
    parameter int W          = 24,
    parameter int NREQ       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*W-1:0]         req_a_r,
    input  logic [NREQ*W-1:0]         req_a_i,
    input  logic [NREQ*(W+1)-1:0]     req_b_r,
    input  logic [NREQ*(W+1)-1:0]     req_b_i,
    output logic                      mul_start,
    output logic [W-1:0]              mul_a_r,
    output logic [W-1:0]              mul_a_i,
    output logic [W:0]                mul_b_r,
    output logic [W:0]                mul_b_i,
    input  logic [W-1:0]              mul_o_r,
    input  logic [W-1:0]              mul_o_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NREQ)-1:0]   out_id,
    output logic [W-1:0]              out_r,
    output logic [W-1:0]              out_i,
    output logic                      busy,
    output logic [15:0]               op_cnt
);

    localparam int c_idw = $clog2(NREQ);
    localparam int c_aw  = $clog2(FIFO_DEPTH);
    localparam int c_ew  = c_idw + 2 * W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_A = 2'd1,
        PH_B = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [c_idw-1:0]                 ptr_q, ptr_d;
    logic [W-1:0]                     a_r_q, a_r_d, a_i_q, a_i_d;
    logic [W:0]                       b_i_q, b_i_d, mul_b_q, mul_b_d;
    logic [1:0]                       inflight_q, inflight_d;
    logic [2:0]                       pv_q, pv_d;
    logic [2:0][c_idw-1:0]            pid_q, pid_d;
    logic [FIFO_DEPTH-1:0][c_ew-1:0]  mem_q, mem_d;
    logic [c_aw-1:0]                  wr_q, wr_d, rd_q, rd_d;
    logic [c_aw:0]                    cnt_q, cnt_d;
    logic [15:0]                      op_cnt_q, op_cnt_d;

    logic                             grant, credit_ok, push, pop;
    logic [c_idw-1:0]                 gnt_id;
    logic [NREQ-1:0]                  gnt_vec;
    logic [c_ew-1:0]                  head;

    assign push = pv_q[2];
    assign pop  = out_valid && out_ready;

    // Credit counts ops already in flight so a grant can never overflow the FIFO.
    always_comb begin
        grant     = 1'b0;
        gnt_id    = '0;
        gnt_vec   = '0;
        credit_ok = (32'(cnt_q) + 32'(inflight_q)) < 32'(FIFO_DEPTH);
        if ((state_q == IDLE || state_q == PH_B) && credit_ok) begin
            // Lowest valid index above ptr wins; otherwise wrap to lowest at/below ptr.
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[k] && k <= int'(ptr_q)) begin
                    grant  = 1'b1;
                    gnt_id = c_idw'(k);
                end
            end
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[k] && k > int'(ptr_q)) begin
                    grant  = 1'b1;
                    gnt_id = c_idw'(k);
                end
            end
        end
        if (grant) gnt_vec[gnt_id] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        a_r_d      = a_r_q;
        a_i_d      = a_i_q;
        b_i_d      = b_i_q;
        mul_b_d    = mul_b_q;
        inflight_d = inflight_q;
        pv_d       = {pv_q[1:0], grant};
        pid_d      = {pid_q[1:0], gnt_id};
        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        op_cnt_d   = op_cnt_q;

        unique case (state_q)
            IDLE:    if (grant) state_d = PH_A;
            PH_A:    state_d = PH_B;
            PH_B:    state_d = grant ? PH_A : IDLE;
            default: state_d = IDLE;
        endcase

        if (grant) begin
            ptr_d   = gnt_id;
            a_r_d   = req_a_r[gnt_id*W +: W];
            a_i_d   = req_a_i[gnt_id*W +: W];
            b_i_d   = req_b_i[gnt_id*(W+1) +: (W+1)];
            mul_b_d = req_b_r[gnt_id*(W+1) +: (W+1)];
        end else if (state_q == PH_A) begin
            mul_b_d = b_i_q;
        end

        case ({grant, push})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase

        if (push) begin
            mem_d[wr_q] = {pid_q[2], mul_o_r, mul_o_i};
            wr_d        = wr_q + c_aw'(1);
            op_cnt_d    = op_cnt_q + 16'd1;
        end
        if (pop) rd_d = rd_q + c_aw'(1);
        if (push && !pop)      cnt_d = cnt_q + (c_aw+1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (c_aw+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= c_idw'(NREQ - 1);
            a_r_q      <= '0;
            a_i_q      <= '0;
            b_i_q      <= '0;
            mul_b_q    <= '0;
            inflight_q <= '0;
            pv_q       <= '0;
            pid_q      <= '0;
            mem_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            op_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            a_r_q      <= a_r_d;
            a_i_q      <= a_i_d;
            b_i_q      <= b_i_d;
            mul_b_q    <= mul_b_d;
            inflight_q <= inflight_d;
            pv_q       <= pv_d;
            pid_q      <= pid_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            op_cnt_q   <= op_cnt_d;
        end
    end

    assign head      = mem_q[rd_q];
    assign req_ready = gnt_vec;
    assign mul_start = (state_q == PH_A);
    assign mul_a_r   = a_r_q;
    assign mul_a_i   = a_i_q;
    assign mul_b_r   = mul_b_q;
    assign mul_b_i   = mul_b_q;
    assign out_valid = (cnt_q != '0);
    assign {out_id, out_r, out_i} = out_valid ? head : '0;
    assign busy      = (state_q != IDLE) || (inflight_q != 2'd0);
    assign op_cnt    = op_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cmul_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmul_sched
// Purpose  : Self-checking bench for cmul_sched with a stand-in multiplier.
// Revision : 1.0
// ============================================================================
module tb_cmul_sched;

    localparam int W     = 24;
    localparam int WB    = W + 1;
    localparam int NREQ  = 4;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_a_r, req_a_i;
    logic [NREQ*WB-1:0]   req_b_r, req_b_i;
    logic                 mul_start;
    logic [W-1:0]         mul_a_r, mul_a_i;
    logic [WB-1:0]        mul_b_r, mul_b_i;
    logic [W-1:0]         mul_o_r, mul_o_i;
    logic                 out_valid, out_ready;
    logic [IDW-1:0]       out_id;
    logic [W-1:0]         out_r, out_i;
    logic                 busy;
    logic [15:0]          op_cnt;

    int errors = 0;
    int checks = 0;

    cmul_sched #(.W(W), .NREQ(NREQ), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a_r(req_a_r), .req_a_i(req_a_i), .req_b_r(req_b_r), .req_b_i(req_b_i),
        .mul_start(mul_start), .mul_a_r(mul_a_r), .mul_a_i(mul_a_i),
        .mul_b_r(mul_b_r), .mul_b_i(mul_b_i), .mul_o_r(mul_o_r), .mul_o_i(mul_o_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_r(out_r), .out_i(out_i), .busy(busy), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    // Bit-exact complex product, Q-format shift by W-1 with round-half-up and saturation.
    function automatic logic [2*W-1:0] cmul_ref(input logic [W-1:0] ar, input logic [W-1:0] ai,
                                                input logic [WB-1:0] br, input logic [WB-1:0] bi);
        longint pr, pi, lim;
        pr  = longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ai)) * longint'($signed(bi));
        pi  = longint'($signed(ar)) * longint'($signed(bi)) + longint'($signed(ai)) * longint'($signed(br));
        pr  = (pr + (64'sd1 <<< (W - 2))) >>> (W - 1);
        pi  = (pi + (64'sd1 <<< (W - 2))) >>> (W - 1);
        lim = (64'sd1 <<< (W - 1));
        if (pr > lim - 1) pr = lim - 1; else if (pr < -lim) pr = -lim;
        if (pi > lim - 1) pi = lim - 1; else if (pi < -lim) pi = -lim;
        return {pr[W-1:0], pi[W-1:0]};
    endfunction

    // Stand-in two-phase multiplier: b_r with start, b_i the cycle after, result held afterwards.
    logic [WB-1:0] sm_br;
    logic          sm_ph;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sm_ph   <= 1'b0;
            sm_br   <= '0;
            mul_o_r <= '0;
            mul_o_i <= '0;
        end else if (mul_start) begin
            sm_br <= mul_b_r;
            sm_ph <= 1'b1;
        end else if (sm_ph) begin
            sm_ph <= 1'b0;
            {mul_o_r, mul_o_i} <= cmul_ref(mul_a_r, mul_a_i, sm_br, mul_b_r);
        end
    end

    // Reference model: expected grant each cycle and ordered queue of expected results.
    logic [IDW+2*W-1:0] mq[$];
    int                 mptr = NREQ - 1;
    bit                 mlast = 1'b0;
    int                 mk;
    logic [NREQ-1:0]    exp_g;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            mptr  = NREQ - 1;
            mlast = 1'b0;
        end else begin
            exp_g = '0;
            mk    = -1;
            if (!mlast && mq.size() < DEPTH) begin
                for (int i = 1; i <= NREQ; i++)
                    if (mk < 0 && req_valid[(mptr + i) % NREQ]) mk = (mptr + i) % NREQ;
            end
            if (mk >= 0) exp_g[mk] = 1'b1;
            checks++;
            if (req_ready !== exp_g) begin
                errors++;
                $display("FAIL grant at %0t: req_ready=%b expected %b", $time, req_ready, exp_g);
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result at %0t: got id=%0d r=%h i=%h, none expected",
                             $time, out_id, out_r, out_i);
                end else if ({out_id, out_r, out_i} !== mq[0]) begin
                    errors++;
                    $display("FAIL result_order at %0t: got %h expected %h", $time,
                             {out_id, out_r, out_i}, mq[0]);
                end
                if (out_ready && mq.size() != 0) void'(mq.pop_front());
            end
            mlast = (mk >= 0);
            if (mk >= 0) begin
                mptr = mk;
                mq.push_back({IDW'(mk), cmul_ref(req_a_r[mk*W +: W], req_a_i[mk*W +: W],
                                                 req_b_r[mk*WB +: WB], req_b_i[mk*WB +: WB])});
            end
        end
    end

    task automatic set_req(input int k, input logic [W-1:0] ar, input logic [W-1:0] ai,
                           input logic [WB-1:0] br, input logic [WB-1:0] bi);
        req_a_r[k*W +: W]   = ar;
        req_a_i[k*W +: W]   = ai;
        req_b_r[k*WB +: WB] = br;
        req_b_i[k*WB +: WB] = bi;
    endtask

    task automatic rand_req(input int k);
        set_req(k, W'($urandom()), W'($urandom()), WB'($urandom()), WB'($urandom()));
    endtask

    task automatic drain();
        @(posedge clk); #1;
        req_valid = '0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, mul_start, busy} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b start=%b busy=%b, expected zeros", req_ready, mul_start, busy);
        end
        checks++;
        if ({mul_a_r, mul_a_i, mul_b_r, mul_b_i} !== '0) begin
            errors++;
            $display("FAIL reset_operands: got %h expected 0", {mul_a_r, mul_a_i, mul_b_r, mul_b_i});
        end
        checks++;
        if ({out_valid, out_id, out_r, out_i} !== '0) begin
            errors++;
            $display("FAIL reset_out: got %h expected 0", {out_valid, out_id, out_r, out_i});
        end
        checks++;
        if (op_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_opcnt: got %0d expected 0", op_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit got = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        set_req(0, 24'h400000, 24'h000000, 25'h0800000, 25'h0000000);
        req_valid = 4'b0001;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = (req_ready === 4'b0001);
        end
        checks++;
        if (!got) begin errors++; $display("FAIL single_grant: got no grant, expected req0 grant"); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({mul_start, busy, mul_a_r, mul_b_r} !== {1'b1, 1'b1, 24'h400000, 25'h0800000}) begin
            errors++;
            $display("FAIL single_pha: got start=%b busy=%b a=%h b=%h expected 1 1 400000 0800000",
                     mul_start, busy, mul_a_r, mul_b_r);
        end
        @(negedge clk);
        checks++;
        if ({mul_start, mul_a_r, mul_b_r} !== {1'b0, 24'h400000, 25'h0}) begin
            errors++;
            $display("FAIL single_phb: got start=%b a=%h b=%h expected 0 400000 0", mul_start, mul_a_r, mul_b_r);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: got out_valid=%b expected 0", out_valid); end
        @(negedge clk);
        checks++;
        if ({out_valid, out_id, out_r, out_i} !== {1'b1, 2'd0, 24'h400000, 24'h0}) begin
            errors++;
            $display("FAIL single_result: got v=%b id=%0d r=%h i=%h expected 1 0 400000 0",
                     out_valid, out_id, out_r, out_i);
        end
        drain();
        checks++;
        if (op_cnt !== 16'd1) begin errors++; $display("FAIL single_opcnt: got %0d expected 1", op_cnt); end
    endtask

    task automatic test_round_robin();
        int last = -1, lastc = 0, ng = 0, id;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) rand_req(k);
        req_valid = '1;
        for (int c = 0; c < 24; c++) begin
            id = -1;
            @(negedge clk);
            if (req_ready !== '0) begin
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) id = k;
                if (last >= 0) begin
                    checks++;
                    if (id != (last + 1) % NREQ || c - lastc != 2) begin
                        errors++;
                        $display("FAIL rr_order: got id=%0d gap=%0d expected id=%0d gap=2",
                                 id, c - lastc, (last + 1) % NREQ);
                    end
                end
                last  = id;
                lastc = c;
                ng++;
            end
            @(posedge clk); #1;
            if (id >= 0) rand_req(id);
        end
        checks++;
        if (ng != 12) begin errors++; $display("FAIL rr_count: got %0d grants expected 12", ng); end
        drain();
    endtask

    task automatic test_backpressure();
        int ng = 0, npop = 0;
        bit g;
        logic [15:0] opc0;
        @(posedge clk); #1;
        opc0      = op_cnt;
        out_ready = 1'b0;
        rand_req(0);
        req_valid = 4'b0001;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            g = req_ready[0];
            if (g) ng++;
            @(posedge clk); #1;
            if (g) rand_req(0);
        end
        checks++;
        if (ng != DEPTH) begin errors++; $display("FAIL bp_grants: got %0d expected %0d", ng, DEPTH); end
        @(negedge clk);
        checks++;
        if ({req_ready, out_valid} !== {4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL bp_stall: got ready=%b out_valid=%b expected 0000 1", req_ready, out_valid);
        end
        @(posedge clk); #1;
        req_valid = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) npop++;
        end
        checks++;
        if (npop != DEPTH) begin errors++; $display("FAIL bp_drain: got %0d pops expected %0d", npop, DEPTH); end
        checks++;
        if (op_cnt !== 16'(opc0 + DEPTH)) begin
            errors++;
            $display("FAIL bp_opcnt: got %0d expected %0d", op_cnt, 16'(opc0 + DEPTH));
        end
        drain();
    endtask

    task automatic test_saturation();
        bit got = 1'b0;
        logic [2*W-1:0] exp;
        exp = cmul_ref(24'h7FFFFF, 24'h7FFFFF, 25'h0FFFFFF, 25'h1000000);
        @(posedge clk); #1;
        set_req(1, 24'h7FFFFF, 24'h7FFFFF, 25'h0FFFFFF, 25'h1000000);
        req_valid = 4'b0010;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = (req_ready === 4'b0010);
        end
        @(posedge clk); #1;
        req_valid = '0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = (out_valid === 1'b1);
        end
        checks++;
        if (!got) begin errors++; $display("FAIL sat_timeout: got no out_valid, expected a result"); end
        checks++;
        if (out_r !== 24'h7FFFFF) begin errors++; $display("FAIL sat_real: got %h expected 7fffff", out_r); end
        checks++;
        if ({out_id, out_i} !== {2'd1, exp[W-1:0]}) begin
            errors++;
            $display("FAIL sat_imag: got id=%0d i=%h expected id=1 i=%h", out_id, out_i, exp[W-1:0]);
        end
        drain();
    endtask

    task automatic test_pulse();
        bit got = 1'b0;
        @(posedge clk); #1;
        rand_req(0);
        req_valid = 4'b0001;
        for (int c = 0; c < 10 && !got; c++) begin @(negedge clk); got = (req_ready === 4'b0001); end
        @(posedge clk); #1;
        rand_req(1);
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL pulse_pha: got %b expected 0000", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({req_ready, mul_start} !== 5'b0) begin
            errors++;
            $display("FAIL pulse_dropped: got ready=%b start=%b expected 0000 0", req_ready, mul_start);
        end
        drain();
        got = 1'b0;
        rand_req(0);
        req_valid = 4'b0001;
        for (int c = 0; c < 10 && !got; c++) begin @(negedge clk); got = (req_ready === 4'b0001); end
        @(posedge clk); #1;
        rand_req(3);
        req_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL sustain_pha: got %b expected 0000", req_ready); end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL sustain_phb: got %b expected 1000", req_ready); end
        drain();
    endtask

    task automatic test_reset_midop();
        bit got = 1'b0;
        int nv = 0;
        @(posedge clk); #1;
        rand_req(2);
        req_valid = 4'b0100;
        for (int c = 0; c < 10 && !got; c++) begin @(negedge clk); got = (req_ready === 4'b0100); end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, mul_start, busy, out_valid, op_cnt, mul_a_r, mul_b_r} !== '0) begin
            errors++;
            $display("FAIL midop_reset: got ready=%b start=%b busy=%b v=%b opcnt=%0d a=%h b=%h expected zeros",
                     req_ready, mul_start, busy, out_valid, op_cnt, mul_a_r, mul_b_r);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) nv++;
        end
        checks++;
        if (nv != 0 || op_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midop_stale: got %0d valid cycles opcnt=%0d expected 0 0", nv, op_cnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NREQ; k++) rand_req(k);
            req_valid = NREQ'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drain();
        @(negedge clk);
        checks++;
        if (mq.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: got %0d outstanding v=%b busy=%b expected 0 0 0", mq.size(), out_valid, busy);
        end
    endtask

    initial begin
        req_valid = '0;
        req_a_r   = '0;
        req_a_i   = '0;
        req_b_r   = '0;
        req_b_i   = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_pulse();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
